// File: rtl/button_press_emitter_if.sv
// Request/status bundle between a press controller and the pulse emitter.
// The master requests presses; the slave emits them on the buttons bus.
interface button_press_emitter_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   start;
    logic [1:0]             select;
    logic [COUNT_WIDTH-1:0] count;
    logic                   abort;
    logic [2:0]             buttons;
    logic                   busy;
    logic                   done;
    logic [COUNT_WIDTH-1:0] presses_sent;

    modport master (
        output start, select, count, abort,
        input  buttons, busy, done, presses_sent
    );

    modport slave (
        input  start, select, count, abort,
        output buttons, busy, done, presses_sent
    );
endinterface

// File: rtl/button_press_emitter.sv
// Emits N fixed-width press pulses on one of three button lines,
// then raises done for one cycle. All outputs are registered.
module button_press_emitter #(
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int COUNT_WIDTH  = 8
) (
    input logic             clk,
    input logic             rst,
    button_press_emitter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRESS = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int TMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES
                                                      : GAP_CYCLES;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] P_LOAD = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] G_LOAD = TW'(GAP_CYCLES - 1);

    logic [1:0]             state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [1:0]             sel_q, sel_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNT_WIDTH-1:0] sent_q, sent_d;
    logic [2:0]             buttons_q, buttons_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    function automatic logic [2:0] onehot(input logic [1:0] s);
        return 3'b001 << s;
    endfunction

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        sent_d    = sent_q;
        buttons_d = 3'b000;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && bus.select != 2'd3) begin
                    sel_d  = bus.select;
                    cnt_d  = bus.count;
                    sent_d = '0;
                    if (bus.count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = PRESS;
                        timer_d   = P_LOAD;
                        busy_d    = 1'b1;
                        buttons_d = onehot(bus.select);
                    end
                end
            end
            PRESS: begin
                // Abort wins over the final PRESS tick, so the press is not counted.
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d = GAP;
                    timer_d = G_LOAD;
                    sent_d  = sent_q + 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    timer_d   = timer_q - 1'b1;
                    busy_d    = 1'b1;
                    buttons_d = onehot(sel_q);
                end
            end
            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    if (sent_q == cnt_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = PRESS;
                        timer_d   = P_LOAD;
                        busy_d    = 1'b1;
                        buttons_d = onehot(sel_q);
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            sent_q    <= '0;
            buttons_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            sent_q    <= sent_d;
            buttons_q <= buttons_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.buttons      = buttons_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.presses_sent = sent_q;
endmodule

// File: tb/tb_button_press_emitter.sv
// Directed bench for button_press_emitter: default 4/4 timing
// instance plus a 1/1 timing instance sharing clock and reset.
module tb_button_press_emitter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    button_press_emitter_if #(.COUNT_WIDTH(8)) bi ();
    button_press_emitter_if #(.COUNT_WIDTH(8)) bf ();

    button_press_emitter #(
        .PRESS_CYCLES(4), .GAP_CYCLES(4), .COUNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .bus(bi.slave)
    );

    button_press_emitter #(
        .PRESS_CYCLES(1), .GAP_CYCLES(1), .COUNT_WIDTH(8)
    ) dut_fast (
        .clk(clk), .rst(rst), .bus(bf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " buttons"}, 32'(bi.buttons), 32'd0);
        chk({tag, " busy"}, 32'(bi.busy), 32'd0);
        chk({tag, " done"}, 32'(bi.done), 32'd0);
    endtask

    initial begin
        logic [2:0] exp_b;
        int         exp_s;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bi.start = 0; bi.select = 0; bi.count = 0; bi.abort = 0;
        bf.start = 0; bf.select = 0; bf.count = 0; bf.abort = 0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset sent", 32'(bi.presses_sent), 32'd0);
        rst = 1'b1;
        tick();
        chk_idle("post reset");

        // count=3 on button 1; a conflicting start mid-sequence is ignored
        bi.start = 1; bi.select = 2'd1; bi.count = 8'd3;
        tick();
        bi.start = 0; bi.select = 0; bi.count = 0;
        for (int c = 1; c <= 24; c++) begin
            exp_b = (((c - 1) % 8) < 4) ? 3'b010 : 3'b000;
            exp_s = (c - 1) / 8 + ((((c - 1) % 8) >= 4) ? 1 : 0);
            chk($sformatf("seq3 c%0d buttons", c), 32'(bi.buttons),
                32'(exp_b));
            chk($sformatf("seq3 c%0d busy", c), 32'(bi.busy), 32'd1);
            chk($sformatf("seq3 c%0d done", c), 32'(bi.done), 32'd0);
            chk($sformatf("seq3 c%0d sent", c), 32'(bi.presses_sent),
                32'(exp_s));
            if (c == 10) begin
                bi.start = 1; bi.select = 2'd0; bi.count = 8'd7;
            end else begin
                bi.start = 0; bi.select = 0; bi.count = 0;
            end
            tick();
        end
        chk("seq3 done", 32'(bi.done), 32'd1);
        chk("seq3 done busy", 32'(bi.busy), 32'd0);
        chk("seq3 done buttons", 32'(bi.buttons), 32'd0);
        chk("seq3 sent", 32'(bi.presses_sent), 32'd3);
        tick();
        chk_idle("seq3 after");

        // count=0 on button 2
        bi.start = 1; bi.select = 2'd2; bi.count = 8'd0;
        tick();
        bi.start = 0;
        chk("zero done", 32'(bi.done), 32'd1);
        chk("zero busy", 32'(bi.busy), 32'd0);
        chk("zero buttons", 32'(bi.buttons), 32'd0);
        chk("zero sent", 32'(bi.presses_sent), 32'd0);
        tick();
        chk_idle("zero after");

        // invalid select ignored, then a valid request
        bi.start = 1; bi.select = 2'd3; bi.count = 8'd2;
        tick();
        bi.start = 0;
        chk_idle("sel3");
        tick();
        chk_idle("sel3 hold");
        bi.start = 1; bi.select = 2'd0; bi.count = 8'd1;
        tick();
        bi.start = 0;
        chk("valid buttons", 32'(bi.buttons), 32'b001);
        chk("valid busy", 32'(bi.busy), 32'd1);
        repeat (8) tick();
        chk("valid done", 32'(bi.done), 32'd1);
        chk("valid sent", 32'(bi.presses_sent), 32'd1);
        tick();

        // abort during 3rd pulse high phase (cycles 17..20)
        bi.start = 1; bi.select = 2'd2; bi.count = 8'd5;
        tick();
        bi.start = 0;
        repeat (17) tick();
        chk("abort pre buttons", 32'(bi.buttons), 32'b100);
        chk("abort pre sent", 32'(bi.presses_sent), 32'd2);
        bi.abort = 1;
        tick();
        bi.abort = 0;
        chk_idle("abort");
        chk("abort sent", 32'(bi.presses_sent), 32'd2);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("abort hold %0d done", c), 32'(bi.done), 32'd0);
            chk($sformatf("abort hold %0d busy", c), 32'(bi.busy), 32'd0);
        end

        // maximum count is accepted and latched
        bi.start = 1; bi.select = 2'd1; bi.count = 8'hFF;
        tick();
        bi.start = 0;
        repeat (8) tick();
        chk("max busy", 32'(bi.busy), 32'd1);
        chk("max sent", 32'(bi.presses_sent), 32'd1);

        // asynchronous reset mid-GAP (cycles 5..8 of a count=2 run)
        bi.abort = 1;
        tick();
        bi.abort = 0;
        bi.start = 1; bi.select = 2'd0; bi.count = 8'd2;
        tick();
        bi.start = 0;
        repeat (5) tick();
        chk("gap busy", 32'(bi.busy), 32'd1);
        chk("gap buttons", 32'(bi.buttons), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("async rst");
        chk("async rst sent", 32'(bi.presses_sent), 32'd0);
        chk("async rst fast busy", 32'(bf.busy), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk_idle("rst release");

        // 1/1 timing: one-cycle pulse, done at cycle 3
        bf.start = 1; bf.select = 2'd1; bf.count = 8'd1;
        tick();
        bf.start = 0;
        chk("fast c1 buttons", 32'(bf.buttons), 32'b010);
        chk("fast c1 busy", 32'(bf.busy), 32'd1);
        tick();
        chk("fast c2 buttons", 32'(bf.buttons), 32'b000);
        chk("fast c2 busy", 32'(bf.busy), 32'd1);
        chk("fast c2 sent", 32'(bf.presses_sent), 32'd1);
        tick();
        chk("fast c3 done", 32'(bf.done), 32'd1);
        chk("fast c3 busy", 32'(bf.busy), 32'd0);
        tick();
        chk("fast c4 done", 32'(bf.done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
